// File: rtl/pe_conv.sv
`default_nettype none
// ============================================================================
// Module   : pe_conv
// Purpose  : Convolution processing element. Each accepted beat multiplies
//            LANES signed pixel/weight pairs and accumulates their sum over
//            a window of KERNEL_N beats. The window sum is arithmetically
//            shifted right by SHIFT, clipped to the signed DATA_W range and
//            presented on a valid/ready output one cycle after the last beat.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    : clk          - clock, rising edge
//            rst          - asynchronous reset, active low
//            pe_in        - LANES packed signed pixels, lane 0 in the LSBs
//            pe_filter    - LANES packed signed weights, same lane order
//            pe_in_valid  - input beat valid
//            pe_in_ready  - block can accept a beat
//            pe_clear     - synchronous abort of the current window
//            pe_out       - signed, clipped window result
//            pe_vaild     - pe_out holds an unconsumed result
//            pe_out_ready - consumer takes pe_out
//            pe_sat       - current pe_out was clipped (qualified by pe_vaild)
// Options  : define PE_RELU_EN to replace negative shifted sums with zero
//            before clipping.
// ============================================================================
module pe_conv #(
  parameter int DATA_W   = 8,
  parameter int KERNEL_N = 9,
  parameter int LANES    = 1,
  parameter int SHIFT    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES*DATA_W-1:0]   pe_in,
  input  logic [LANES*DATA_W-1:0]   pe_filter,
  input  logic                      pe_in_valid,
  output logic                      pe_in_ready,
  input  logic                      pe_clear,
  output logic [DATA_W-1:0]         pe_out,
  output logic                      pe_vaild,
  input  logic                      pe_out_ready,
  output logic                      pe_sat
);

  // Wide enough that KERNEL_N*LANES full-scale products never overflow.
  localparam int c_acc_w = 2*DATA_W + $clog2(KERNEL_N*LANES);
  localparam int c_cnt_w = (KERNEL_N > 1) ? $clog2(KERNEL_N) : 1;
  localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(KERNEL_N-1);
  localparam logic signed [c_acc_w-1:0] c_sat_max =
    {{(c_acc_w-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [c_acc_w-1:0] c_sat_min =
    {{(c_acc_w-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_LAST  = 1'b1
  } state_t;

  state_t                      r_state, w_state_nxt;
  logic [c_cnt_w-1:0]          r_cnt, w_cnt_nxt;
  logic signed [c_acc_w-1:0]   r_acc;
  logic signed [c_acc_w-1:0]   w_beat_sum, w_win_sum, w_shifted, w_relu;
  logic signed [DATA_W-1:0]    w_px, w_wt;
  logic signed [2*DATA_W-1:0]  w_prod;
  logic [DATA_W-1:0]           r_out, w_clip;
  logic                        r_vaild, r_sat, w_clipped;
  logic                        w_in_last, w_accept, w_final, w_in_ready;

  // --------------------------------------------------------------------------
  // Datapath: sum of lane products for this beat, then window sum.
  // --------------------------------------------------------------------------
  always_comb begin
    w_beat_sum = '0;
    w_px       = '0;
    w_wt       = '0;
    w_prod     = '0;
    for (int i = 0; i < LANES; i++) begin
      w_px       = pe_in[i*DATA_W +: DATA_W];
      w_wt       = pe_filter[i*DATA_W +: DATA_W];
      w_prod     = (2*DATA_W)'(w_px) * (2*DATA_W)'(w_wt);
      w_beat_sum = w_beat_sum + c_acc_w'(w_prod);
    end
  end

  // Beat 0 loads rather than adds, so a new window needs no clearing bubble.
  assign w_win_sum = (r_cnt == '0) ? w_beat_sum : (r_acc + w_beat_sum);
  assign w_shifted = w_win_sum >>> SHIFT;

`ifdef PE_RELU_EN
  assign w_relu = w_shifted[c_acc_w-1] ? '0 : w_shifted;
`else
  assign w_relu = w_shifted;
`endif

  always_comb begin
    w_clip    = w_relu[DATA_W-1:0];
    w_clipped = 1'b0;
    if (w_relu > c_sat_max) begin
      w_clip    = c_sat_max[DATA_W-1:0];
      w_clipped = 1'b1;
    end else if (w_relu < c_sat_min) begin
      w_clip    = c_sat_min[DATA_W-1:0];
      w_clipped = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM. A single-beat kernel is always on its final beat, so it is
  // treated as LAST regardless of the registered state.
  // --------------------------------------------------------------------------
  assign w_in_last = (r_state == ST_LAST) || (KERNEL_N == 1);
  assign w_accept  = pe_in_valid && w_in_ready && !pe_clear;
  assign w_final   = w_accept && (r_cnt == c_last_beat);

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_state_nxt = ST_ACCUM;
    // Stall only the final beat, and only while an unconsumed result would
    // be overwritten. Independent of pe_in_valid.
    w_in_ready  = !(w_in_last && r_vaild && !pe_out_ready);
    if (pe_clear) begin
      w_cnt_nxt = '0;
    end else if (w_accept) begin
      w_cnt_nxt = (r_cnt == c_last_beat) ? '0 : (r_cnt + c_cnt_w'(1));
    end
    if (!pe_clear && (w_cnt_nxt == c_last_beat)) begin
      w_state_nxt = ST_LAST;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_ACCUM;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_acc <= w_win_sum;
      end
    end
  end

  // Output register: a new result may replace one being consumed in the
  // same cycle; pe_clear deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out   <= '0;
      r_sat   <= 1'b0;
      r_vaild <= 1'b0;
    end else if (w_final) begin
      r_out   <= w_clip;
      r_sat   <= w_clipped;
      r_vaild <= 1'b1;
    end else if (r_vaild && pe_out_ready) begin
      r_vaild <= 1'b0;
    end
  end

  assign pe_in_ready = w_in_ready;
  assign pe_out      = r_out;
  assign pe_vaild    = r_vaild;
  assign pe_sat      = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_pe_conv.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_conv
// Purpose  : Self-checking bench for pe_conv. Three instances run in lockstep
//            on shared handshakes: A (1 lane, SHIFT 0), B (1 lane, SHIFT 4)
//            and C (4 lanes, SHIFT 0). A and B see lane 0 of the stimulus.
//            Build with PE_RELU_EN defined to check the ReLU variant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_conv;

  logic        clk;
  logic        rst;
  logic [31:0] px4, wt4;
  logic        vld, clr, ord;

  logic        rdy_a, rdy_b, rdy_c;
  logic [7:0]  out_a, out_b, out_c;
  logic        vaild_a, vaild_b, vaild_c;
  logic        sat_a, sat_b, sat_c;

  int total = 0;
  int bad   = 0;

  pe_conv #(.DATA_W(8), .KERNEL_N(9), .LANES(1), .SHIFT(0)) u_dut_a (
    .clk(clk), .rst(rst), .pe_in(px4[7:0]), .pe_filter(wt4[7:0]),
    .pe_in_valid(vld), .pe_in_ready(rdy_a), .pe_clear(clr),
    .pe_out(out_a), .pe_vaild(vaild_a), .pe_out_ready(ord), .pe_sat(sat_a));

  pe_conv #(.DATA_W(8), .KERNEL_N(9), .LANES(1), .SHIFT(4)) u_dut_b (
    .clk(clk), .rst(rst), .pe_in(px4[7:0]), .pe_filter(wt4[7:0]),
    .pe_in_valid(vld), .pe_in_ready(rdy_b), .pe_clear(clr),
    .pe_out(out_b), .pe_vaild(vaild_b), .pe_out_ready(ord), .pe_sat(sat_b));

  pe_conv #(.DATA_W(8), .KERNEL_N(9), .LANES(4), .SHIFT(0)) u_dut_c (
    .clk(clk), .rst(rst), .pe_in(px4), .pe_filter(wt4),
    .pe_in_valid(vld), .pe_in_ready(rdy_c), .pe_clear(clr),
    .pe_out(out_c), .pe_vaild(vaild_c), .pe_out_ready(ord), .pe_sat(sat_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_res(input string nm, input int ea, input int sa,
                         input int eb, input int sb, input int ec, input int sc);
    chk({nm, ".vaild_a"}, vaild_a, 1);
    chk({nm, ".vaild_b"}, vaild_b, 1);
    chk({nm, ".vaild_c"}, vaild_c, 1);
    chk({nm, ".out_a"}, $signed(out_a), ea);
    chk({nm, ".sat_a"}, sat_a, sa);
    chk({nm, ".out_b"}, $signed(out_b), eb);
    chk({nm, ".sat_b"}, sat_b, sb);
    chk({nm, ".out_c"}, $signed(out_c), ec);
    chk({nm, ".sat_c"}, sat_c, sc);
  endtask

  // Drive nb consecutive beats of one pixel/weight pair on every lane.
  // Entered and left at posedge+1; vld drops when done.
  task automatic drive_window(input int px, input int wt, input int nb,
                              input bit chk_flow);
    logic [7:0] p, w;
    p = px[7:0];
    w = wt[7:0];
    for (int b = 0; b < nb; b++) begin
      px4 = {4{p}};
      wt4 = {4{w}};
      vld = 1'b1;
      if (chk_flow) begin
        chk("flow.rdy_a", rdy_a, 1);
        chk("flow.rdy_c", rdy_c, 1);
      end
      @(posedge clk);
      #1;
      if (chk_flow) chk("flow.vaild_a", vaild_a, (b == nb-1) ? 1 : 0);
    end
    vld = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic int relu(input int v);
`ifdef PE_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int clip8(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  int q0[$];   // lane-0 products of the open window
  int q4[$];   // all-lane beat sums of the open window
  bit mv;
  int ea, eb, ec, sa, sb, sc;

  task automatic model_edge(input bit acc);
    int p0, p4, s0, s4;
    bit load;
    load = 1'b0;
    if (clr) begin
      q0.delete();
      q4.delete();
    end else if (acc) begin
      p4 = 0;
      for (int l = 0; l < 4; l++)
        p4 += int'($signed(px4[8*l +: 8])) * int'($signed(wt4[8*l +: 8]));
      p0 = int'($signed(px4[7:0])) * int'($signed(wt4[7:0]));
      q0.push_back(p0);
      q4.push_back(p4);
      if (q0.size() == 9) begin
        s0 = 0; s4 = 0;
        foreach (q0[k]) s0 += q0[k];
        foreach (q4[k]) s4 += q4[k];
        ea = clip8(relu(s0));       sa = (ea != relu(s0)) ? 1 : 0;
        eb = clip8(relu(s0 >>> 4)); sb = (eb != relu(s0 >>> 4)) ? 1 : 0;
        ec = clip8(relu(s4));       sc = (ec != relu(s4)) ? 1 : 0;
        q0.delete();
        q4.delete();
        load = 1'b1;
      end
    end
    if (load) mv = 1'b1;
    else if (mv && ord) mv = 1'b0;
  endtask

  typedef struct {
    int px; int wt;
    int ea; int sa; int eb; int sb; int ec; int sc;
  } vec_t;
  vec_t tbl[6];

  initial begin
    bit rdy_exp;
    tbl[0] = '{2, 2,       36, 0,   2, 0,  127, 1};
    tbl[1] = '{10, 10,    127, 1,  56, 0,  127, 1};
    tbl[2] = '{1, 2,       18, 0,   1, 0,   72, 0};
    tbl[3] = '{-128, -128, 127, 1, 127, 1,  127, 1};
`ifdef PE_RELU_EN
    tbl[4] = '{-3, 5,       0, 0,   0, 0,    0, 0};
    tbl[5] = '{-128, 127,   0, 0,   0, 0,    0, 0};
`else
    tbl[4] = '{-3, 5,    -128, 1,  -9, 0, -128, 1};
    tbl[5] = '{-128, 127, -128, 1, -128, 1, -128, 1};
`endif

    px4 = '0; wt4 = '0; vld = 1'b0; clr = 1'b0; ord = 1'b1;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst.vaild_a", vaild_a, 0);
    chk("rst.out_a", $signed(out_a), 0);
    chk("rst.sat_a", sat_a, 0);
    chk("rst.rdy_a", rdy_a, 1);
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst.rdy_a", rdy_a, 1);

    // Result held across a stalled second window, then handed over.
    ord = 1'b0;
    drive_window(2, 2, 9, 1'b0);
    chk_res("hold.w1", 36, 0, 2, 0, 127, 1);
    drive_window(2, 2, 8, 1'b0);
    chk("hold.keep_out", $signed(out_a), 36);
    chk("hold.keep_v", vaild_a, 1);
    px4 = {4{8'd2}}; wt4 = {4{8'd2}}; vld = 1'b1;
    #1 chk("hold.rdy_low_a", rdy_a, 0);
    chk("hold.rdy_low_c", rdy_c, 0);
    @(posedge clk); #1;
    chk("hold.stall_v", vaild_a, 1);
    chk("hold.stall_out", $signed(out_a), 36);
    chk("hold.stall_rdy", rdy_a, 0);
    ord = 1'b1;
    #1 chk("hold.rdy_back", rdy_a, 1);
    @(posedge clk); #1;
    vld = 1'b0;
    chk_res("hold.w2", 36, 0, 2, 0, 127, 1);
    @(posedge clk); #1;
    chk("hold.drained", vaild_a, 0);
    drive_window(1, 2, 9, 1'b1);
    chk_res("hold.after", 18, 0, 1, 0, 72, 0);

    // Reset mid-window discards the partial sum.
    drive_window(10, 10, 4, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("midrst.vaild", vaild_a, 0);
    chk("midrst.out", $signed(out_a), 0);
    chk("midrst.rdy", rdy_a, 1);
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    drive_window(5, 5, 9, 1'b1);
    chk_res("midrst.res", 127, 1, 14, 0, 127, 1);

    // Clear mid-window: result register untouched, partial sum dropped.
    ord = 1'b0;
    drive_window(2, 2, 4, 1'b0);
    clr = 1'b1; vld = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; vld = 1'b0;
    chk("clear.keep_v", vaild_a, 1);
    chk("clear.keep_out", $signed(out_a), 127);
    chk("clear.keep_sat", sat_a, 1);
    ord = 1'b1;
    drive_window(2, 2, 9, 1'b1);
    chk_res("clear.res", 36, 0, 2, 0, 127, 1);

    // Table of back-to-back windows with the consumer always ready.
    foreach (tbl[i]) begin
      drive_window(tbl[i].px, tbl[i].wt, 9, 1'b1);
      chk_res($sformatf("tbl%0d", i), tbl[i].ea, tbl[i].sa, tbl[i].eb,
              tbl[i].sb, tbl[i].ec, tbl[i].sc);
    end

    // Randomized traffic against the reference model, from a clean reset.
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    mv = 1'b0;
    q0.delete();
    q4.delete();
    for (int n = 0; n < 1500; n++) begin
      px4 = $urandom;
      wt4 = $urandom;
      vld = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      ord = ($urandom_range(0, 2) != 0);
      rdy_exp = !((q0.size() == 8) && mv && !ord);
      #1;
      chk("rnd.rdy_a", rdy_a, rdy_exp);
      chk("rnd.rdy_c", rdy_c, rdy_exp);
      @(posedge clk);
      model_edge(vld && rdy_exp && !clr);
      #1;
      chk("rnd.vaild_a", vaild_a, mv);
      chk("rnd.vaild_c", vaild_c, mv);
      if (mv) begin
        chk("rnd.out_a", $signed(out_a), ea);
        chk("rnd.sat_a", sat_a, sa);
        chk("rnd.out_b", $signed(out_b), eb);
        chk("rnd.sat_b", sat_b, sb);
        chk("rnd.out_c", $signed(out_c), ec);
        chk("rnd.sat_c", sat_c, sc);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pe_conv.md
PE_CONV -- requirements
Module: pe_conv

Interface
REQ-001 SHALL have parameter DATA_W, default 8: signed width of each pixel, filter and output value.
REQ-002 SHALL have parameter KERNEL_N, default 9: number of accepted beats per window (min 1).
REQ-003 SHALL have parameter LANES, default 1: products summed per beat.
REQ-004 SHALL have parameter SHIFT, default 0: arithmetic right shift applied to the window sum before saturation.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port pe_in, input, LANES*DATA_W: packed signed pixels, lane 0 in the LSBs.
REQ-008 SHALL have port pe_filter, input, LANES*DATA_W: packed signed weights, same lane order as pe_in.
REQ-009 SHALL have port pe_in_valid, input, 1: the beat on pe_in and pe_filter is valid.
REQ-010 SHALL have port pe_in_ready, output, 1: the block can accept a beat.
REQ-011 SHALL have port pe_clear, input, 1: synchronous abort of the current window.
REQ-012 SHALL have port pe_out, output, DATA_W: signed window result.
REQ-013 SHALL have port pe_vaild, output, 1: pe_out holds an unconsumed result.
REQ-014 SHALL have port pe_out_ready, input, 1: the consumer takes pe_out.
REQ-015 SHALL have port pe_sat, output, 1: the current pe_out was clipped; qualified by pe_vaild.

Function
REQ-016 SHALL accept a beat only in a cycle where pe_in_valid=1 and pe_in_ready=1.
REQ-017 SHALL hold internal accumulator width 2*DATA_W+clog2(KERNEL_N*LANES) so no intermediate overflow occurs.
REQ-018 SHALL, per accepted beat, add the sum of all LANES signed products pe_in[i]*pe_filter[i] to the accumulator.
REQ-019 SHALL load (not add) on beat 0 of a window, so back-to-back windows have no bubble.
REQ-020 SHALL count beats 0..KERNEL_N-1 and wrap to 0 after the final beat is accepted.
REQ-021 SHALL use state machine ACCUM (beats 0..KERNEL_N-2) then LAST (final beat pending), returning to ACCUM on final-beat acceptance; KERNEL_N=1 stays in LAST.
REQ-022 SHALL, the cycle after the final beat, set pe_out=sat(sum>>>SHIFT), set pe_vaild=1, and set pe_sat=1 iff clipping occurred (latency 1 cycle).
REQ-023 SHALL clip to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-024 SHALL clear pe_vaild when pe_vaild=1 and pe_out_ready=1, unless a new result loads in the same cycle, in which case pe_vaild stays 1 with the new value.
REQ-025 SHALL hold pe_out and pe_sat stable while pe_vaild=1 and pe_out_ready=0.
REQ-026 SHALL drive pe_in_ready=0 only when in LAST with pe_vaild=1 and pe_out_ready=0, so an unconsumed result is never overwritten.
REQ-027 SHALL, on pe_clear=1, zero the beat count and return to ACCUM, ignoring any beat in that cycle, while leaving pe_out, pe_vaild and pe_sat untouched.
REQ-028 SHALL make pe_in_ready a combinational function of state, pe_vaild and pe_out_ready only (no dependence on pe_in_valid).

Reset
REQ-029 SHALL, while rst=0, asynchronously force pe_out=0, pe_vaild=0, pe_sat=0, beat count=0, accumulator=0 and state ACCUM.
REQ-030 SHALL discard any partial window on reset mid-operation; the first accepted beat after release is beat 0.
REQ-031 SHALL drive pe_in_ready=1 during and directly after reset.

Configuration
REQ-032 SHALL, with macro PE_RELU_EN defined, replace negative shifted sums with 0 before saturation (pe_sat=0 for those results).
REQ-033 SHALL, without PE_RELU_EN, saturate negative sums to the signed minimum as in REQ-023.

Verification (DATA_W=8, KERNEL_N=9, LANES=1, SHIFT=0 unless stated)
REQ-034 SHALL cover: 9 beats of 2x2 -> pe_out=36, pe_sat=0, pe_vaild high one cycle after beat 9; 9 beats of 10x10 -> pe_out=127, pe_sat=1; with SHIFT=4, 9 beats of 10x10 -> pe_out=56, pe_sat=0.
REQ-035 SHALL cover: 9 beats of -3x5 -> pe_out=-128, pe_sat=1 without PE_RELU_EN; pe_out=0, pe_sat=0 with it.
REQ-036 SHALL cover: pe_out_ready=0 across two windows (36, 36) -> first 36 held, pe_in_ready=0 at the final beat of window 2, then pe_out_ready=1 -> two consecutive results, no beat lost.
REQ-037 SHALL cover: rst low after 4 beats of 10x10, then 9 beats of 5x5 -> pe_out=127, pe_sat=1 with no residue, and pe_clear after 4 beats followed by 9 beats of 2x2 -> 36.
REQ-038 SHALL cover: LANES=4, 9 beats with every lane 1x2 -> pe_out=72; continuous back-to-back windows with pe_out_ready=1 -> pe_vaild every 9th cycle, pe_in_ready constantly 1.
